// File: rtl/can_rx_reader.sv
// Canakari receive reader: reads ID/data registers on rx_irq and hands a 76-bit message to the bridge.
// Optional read-acknowledge timeout enabled by defining CAN_RX_TIMEOUT_EN.
module can_rx_reader #(
  parameter logic [4:0] ADDR_RX_ID  = 5'h06,
  parameter logic [4:0] ADDR_RX_D12 = 5'h03,
  parameter logic [4:0] ADDR_RX_D34 = 5'h02,
  parameter logic [4:0] ADDR_RX_D56 = 5'h01,
  parameter logic [4:0] ADDR_RX_D78 = 5'h00,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_irq,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic        irq_clr,
  output logic        mes_valid,
  input  logic        mes_ack,
  output logic [75:0] data_rec_mes,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_ACK, NEXT, CLR, HOLD
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  idx;
  logic [75:0] shadow;
  logic [4:0]  addr_sel;
  logic        tmo;

  // Low ID bits carry no identifier information.
  logic unused_id_bits;
  assign unused_id_bits = ^rd_data[4:0];

  always_comb begin
    addr_sel = ADDR_RX_ID;
    unique case (idx)
      3'd0: addr_sel = ADDR_RX_ID;
      3'd1: addr_sel = ADDR_RX_D12;
      3'd2: addr_sel = ADDR_RX_D34;
      3'd3: addr_sel = ADDR_RX_D56;
      3'd4: addr_sel = ADDR_RX_D78;
      default: addr_sel = ADDR_RX_ID;
    endcase
  end

`ifdef CAN_RX_TIMEOUT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state == REQ)
      cnt <= '0;
    else if (state == WAIT_ACK && !rd_ack)
      cnt <= cnt + 16'd1;
  end

  assign tmo = (state == WAIT_ACK) && !rd_ack
            && (cnt == 16'(ACK_TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (rx_irq) state_nx = REQ;
      REQ:      state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (rd_ack)   state_nx = NEXT;
        else if (tmo) state_nx = IDLE;
      end
      NEXT:     state_nx = (idx == 3'd4) ? CLR : REQ;
      CLR:      state_nx = HOLD;
      HOLD:     if (mes_valid && mes_ack) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      shadow       <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      irq_clr      <= 1'b0;
      mes_valid    <= 1'b0;
      data_rec_mes <= '0;
      timeout_err  <= 1'b0;
    end else begin
      irq_clr     <= 1'b0;
      timeout_err <= tmo;
      unique case (state)
        IDLE: if (rx_irq) idx <= '0;
        REQ: begin
          rd_req  <= 1'b1;
          rd_addr <= addr_sel;
        end
        WAIT_ACK: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            unique case (idx)
              3'd0: shadow[74:64] <= rd_data[15:5];
              3'd1: begin
                shadow[63:56] <= rd_data[15:8];
                shadow[47:40] <= rd_data[7:0];
              end
              3'd2: begin
                shadow[55:48] <= rd_data[15:8];
                shadow[39:32] <= rd_data[7:0];
              end
              3'd3: begin
                shadow[7:0]  <= rd_data[15:8];
                shadow[15:8] <= rd_data[7:0];
              end
              3'd4: begin
                shadow[23:16] <= rd_data[15:8];
                shadow[31:24] <= rd_data[7:0];
              end
              default: ;
            endcase
          end else if (tmo) begin
            rd_req <= 1'b0;
            shadow <= '0;
          end
        end
        NEXT: if (idx != 3'd4) idx <= idx + 3'd1;
        CLR: begin
          irq_clr      <= 1'b1;
          data_rec_mes <= shadow;
        end
        // First HOLD cycle raises valid; an ack only counts once valid is seen.
        HOLD: mes_valid <= !(mes_valid && mes_ack);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/can_rx_reader.md
Name: can_rx_reader

Overview:
Receive-side companion to the Canakari transmit/config writer. When the Canakari controller raises its receive interrupt, this block reads the receive identifier and data registers through a request/acknowledge read port. It reassembles a 76-bit message using the same bit layout the transmit path uses to split `data_tra_mes`, clears the interrupt, and presents the message to the MOPS-hub bridge with a valid/ack handshake.

Parameters:
- `ADDR_RX_ID`, 5'h06, receive identifier register address
- `ADDR_RX_D12`, 5'h03, receive data bytes 1-2 register address
- `ADDR_RX_D34`, 5'h02, receive data bytes 3-4 register address
- `ADDR_RX_D56`, 5'h01, receive data bytes 5-6 register address
- `ADDR_RX_D78`, 5'h00, receive data bytes 7-8 register address
- `ACK_TIMEOUT`, 255, maximum cycles spent waiting for `rd_ack`; used only with `CAN_RX_TIMEOUT_EN`

Ports:
- `clk`, in, 1, single clock
- `rst`, in, 1, synchronous reset, active-high
- `rx_irq`, in, 1, Canakari receive interrupt (level)
- `rd_req`, out, 1, register read request
- `rd_addr`, out, 5, address of the register being read
- `rd_ack`, in, 1, controller read acknowledge; `rd_data` is valid in this cycle
- `rd_data`, in, 16, register read data
- `irq_clr`, out, 1, one-cycle pulse that clears the receive interrupt
- `mes_valid`, out, 1, `data_rec_mes` holds a complete message
- `mes_ack`, in, 1, consumer accepts the message
- `data_rec_mes`, out, 76, reassembled message
- `busy`, out, 1, high in every state except IDLE
- `timeout_err`, out, 1, one-cycle pulse on read timeout

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge):
  - All outputs are 0 at the next edge; `rd_addr`=0; shadow register cleared; state=IDLE.
  - This applies in any state, including mid-read.
- States: IDLE, REQ, WAIT_ACK, NEXT, CLR, HOLD. A read index `idx` (0..4) selects the address in this order: `ADDR_RX_ID`, `ADDR_RX_D12`, `ADDR_RX_D34`, `ADDR_RX_D56`, `ADDR_RX_D78`.
- IDLE:
  - `rx_irq` is sampled only here.
  - If `rx_irq`=1: set `idx`=0 and go to REQ.
- REQ:
  - Drive `rd_addr` from `idx` and set `rd_req`=1; go to WAIT_ACK.
  - `rd_req` and `rd_addr` stay stable until `rd_ack` is sampled high.
- WAIT_ACK, on `rd_ack`=1:
  - Capture `rd_data` into the shadow register in that cycle.
  - `rd_req` is 0 from the next cycle; go to NEXT.
  - `rd_ack` outside WAIT_ACK is ignored.
- Capture mapping, with w=`rd_data`:
  - ID: shadow[74:64]=w[15:5]; w[4:0] is discarded.
  - D12: [63:56]=w[15:8], [47:40]=w[7:0].
  - D34: [55:48]=w[15:8], [39:32]=w[7:0].
  - D56: [7:0]=w[15:8], [15:8]=w[7:0].
  - D78: [23:16]=w[15:8], [31:24]=w[7:0].
  - shadow[75] is always 0.
- NEXT:
  - If `idx`<4: increment `idx` and go to REQ. This guarantees at least one idle cycle between requests.
  - If `idx`=4: go to CLR.
- CLR:
  - `irq_clr`=1 for exactly one cycle.
  - Copy shadow to `data_rec_mes`; go to HOLD.
- HOLD:
  - `mes_valid`=1 and `data_rec_mes` held stable until `mes_ack`=1 is sampled; then go to IDLE with `mes_valid`=0 next cycle.
  - `mes_ack` while `mes_valid`=0 is ignored.
  - `rx_irq` asserted during HOLD waits; no read is issued (back-pressure).
- Latency:
  - With zero-wait `rd_ack` (ack in the first WAIT_ACK cycle), `mes_valid` rises 17 cycles after `rx_irq` is sampled in IDLE.
  - Each extra ack-wait cycle adds 1.
- `data_rec_mes` changes only on entry to HOLD and keeps its last value after acknowledgement.

Optional Feature:
- Macro: `CAN_RX_TIMEOUT_EN`.
- When defined:
  - An 8-bit+ counter runs in WAIT_ACK and clears on REQ entry.
  - If `ACK_TIMEOUT` cycles elapse with no `rd_ack`: `rd_req`=0, `timeout_err`=1 for one cycle, shadow discarded, return to IDLE.
  - No `irq_clr` and no `mes_valid` are produced; `data_rec_mes` is unchanged.
- When undefined: WAIT_ACK waits indefinitely; `timeout_err` is tied to 0.

Test Plan:
- Basic read, zero-wait ack:
  - Stimulus: `rx_irq`=1, `rd_data` for the ID, D12, D34, D56, D78 reads = 16'hAAA0, 16'h1122, 16'h3344, 16'h5566, 16'h7788.
  - Response: `rd_addr` sequence 06, 03, 02, 01, 00; one `irq_clr` pulse; `data_rec_mes`=76'h555_1133_2244_8877_6655 with `mes_valid`=1 exactly 17 cycles after the irq sample.
- Ack wait states: same data, `rd_ack` delayed 3 cycles on every read → identical message, `mes_valid` at cycle 32; `rd_req`/`rd_addr` stable throughout each wait.
- Back-pressure: hold `mes_ack`=0 for 20 cycles with `rx_irq` kept high → `mes_valid` and data stable, no `rd_req`; `mes_ack`=1 → `mes_valid`=0 next cycle, new read sequence starts the cycle after.
- Reset mid-operation: `rst`=1 while in WAIT_ACK of the D34 read → next cycle `rd_req`, `busy`, `irq_clr`, `mes_valid` = 0; a following `rx_irq` gives a clean 5-read sequence.
- Timeout (`CAN_RX_TIMEOUT_EN`, `ACK_TIMEOUT`=10): no `rd_ack` on the D12 read → after 10 cycles, `timeout_err` pulses once, `rd_req`=0, no `irq_clr`, `mes_valid` stays 0, previous `data_rec_mes` retained.
- Unsolicited ack: `rd_ack`=1 while IDLE and in NEXT → ignored; shadow and outputs unchanged.
